// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: arbitrates instruction-fetch and load read requests onto a
// single AXI AR channel and routes R-channel beats back by rid (0=inst, 1=data).
// Each requester keeps an outstanding-read counter capped at MAX_OUTSTAND-1.
// Optional macro RD_ARB_RR_EN: round-robin arbitration between the two
// requesters; without it data has fixed priority over inst.
//
// Handshake semantics: an AR transfer happens in exactly the cycle where
// arvalid&arready are both 1; arid/araddr/arsize are held stable while arvalid
// is 1 and arready is 0. An R beat is accepted whenever rvalid is 1 (rready is
// tied high); the matching addr_ok/data_ok pulses are combinational in the
// transfer cycle.
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int MAX_OUTSTAND = 5,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [31:0]           inst_rdata,
    input  logic                  data_req,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [2:0]            data_size,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [31:0]           data_rdata,
    output logic [ADDR_WIDTH-1:0] check_addr,
    input  logic                  wr_related,
    output logic [3:0]            arid,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arsize,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [3:0]            rid,
    input  logic [31:0]           rdata,
    input  logic                  rvalid,
    output logic                  rready,
    output logic                  dbg_state
);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(MAX_OUTSTAND - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;      // 0 = inst, 1 = data
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [3:0]            arid_q, arid_d;
    logic [2:0]            arsize_q, arsize_d;
    logic [CNT_WIDTH-1:0]  inst_cnt_q, inst_cnt_d;
    logic [CNT_WIDTH-1:0]  data_cnt_q, data_cnt_d;
`ifdef RD_ARB_RR_EN
    logic                  last_grant_q, last_grant_d;
`endif

    logic inst_elig, data_elig, pick_data, ar_hs;
    logic inst_inc, inst_dec, data_inc, data_dec;

    // Eligibility and arbitration; wr_related only matters while IDLE.
    always_comb begin
        inst_elig = (state_q == IDLE) && inst_req && (inst_cnt_q != CNT_FULL);
        data_elig = (state_q == IDLE) && data_req && !wr_related && (data_cnt_q != CNT_FULL);
`ifdef RD_ARB_RR_EN
        pick_data = data_elig && (!inst_elig || !last_grant_q);
`else
        pick_data = data_elig;
`endif
        ar_hs = (state_q == ISSUE) && arready;
    end

    // FSM next state and latched AR fields; fields only change on a new grant.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        araddr_d = araddr_q;
        arid_d   = arid_q;
        arsize_d = arsize_q;
        case (state_q)
            IDLE: begin
                if (inst_elig || data_elig) begin
                    state_d  = ISSUE;
                    grant_d  = pick_data;
                    araddr_d = pick_data ? data_addr : inst_addr;
                    arid_d   = pick_data ? 4'd1 : 4'd0;
                    arsize_d = pick_data ? data_size : 3'b010;
                end
            end
            ISSUE: begin
                if (arready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef RD_ARB_RR_EN
    // Remember who won the last completed AR so the other side wins a tie.
    always_comb begin
        last_grant_d = last_grant_q;
        if (ar_hs) last_grant_d = grant_q;
    end
`endif

    // Outstanding counters: +1 on AR handshake, -1 on accepted R beat.
    always_comb begin
        inst_inc   = ar_hs && !grant_q;
        data_inc   = ar_hs && grant_q;
        inst_dec   = rvalid && (rid == 4'd0) && (inst_cnt_q != '0);
        data_dec   = rvalid && (rid == 4'd1) && (data_cnt_q != '0);
        inst_cnt_d = inst_cnt_q;
        data_cnt_d = data_cnt_q;
        if (inst_inc && !inst_dec) inst_cnt_d = inst_cnt_q + CNT_ONE;
        if (!inst_inc && inst_dec) inst_cnt_d = inst_cnt_q - CNT_ONE;
        if (data_inc && !data_dec) data_cnt_d = data_cnt_q + CNT_ONE;
        if (!data_inc && data_dec) data_cnt_d = data_cnt_q - CNT_ONE;
    end

    // Outputs; pulses are masked while reset is asserted.
    always_comb begin
        arvalid      = resetn && (state_q == ISSUE);
        arid         = arid_q;
        araddr       = araddr_q;
        arsize       = arsize_q;
        inst_addr_ok = resetn && inst_inc;
        data_addr_ok = resetn && data_inc;
        inst_data_ok = resetn && inst_dec;
        data_data_ok = resetn && data_dec;
        inst_rdata   = rdata;
        data_rdata   = rdata;
        rready       = 1'b1;
        check_addr   = data_addr;
        dbg_state    = (state_q == ISSUE);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            araddr_q   <= '0;
            arid_q     <= '0;
            arsize_q   <= '0;
            inst_cnt_q <= '0;
            data_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            araddr_q   <= araddr_d;
            arid_q     <= arid_d;
            arsize_q   <= arsize_d;
            inst_cnt_q <= inst_cnt_d;
            data_cnt_q <= data_cnt_d;
        end
    end

`ifdef RD_ARB_RR_EN
    // Round-robin history register, starts as "inst granted last".
    always_ff @(posedge clk) begin
        if (!resetn) last_grant_q <= 1'b0;
        else         last_grant_q <= last_grant_d;
    end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the read arbiter (pending AR + per-id counts).
module tb_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int FULL = 4;

  logic clk = 0;
  logic resetn = 0;
  logic inst_req = 0, data_req = 0, wr_related = 0, arready = 0, rvalid = 0;
  logic [AW-1:0] inst_addr = '0, data_addr = '0;
  logic [2:0] data_size = '0;
  logic [3:0] rid = '0;
  logic [31:0] rdata = '0;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, arvalid, rready, dbg_state;
  logic [31:0] inst_rdata, data_rdata;
  logic [AW-1:0] check_addr, araddr;
  logic [3:0] arid;
  logic [2:0] arsize;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  axi_rd_arbiter #(.ADDR_WIDTH(AW), .MAX_OUTSTAND(5), .CNT_WIDTH(3)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .check_addr(check_addr), .wr_related(wr_related),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) started <= 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit pend;            // an AR request is waiting on the bus
    bit pid;             // 0 inst, 1 data
    logic [AW-1:0] paddr;
    logic [2:0] psize;
    int cnt0;            // reads in flight for id 0
    int cnt1;            // reads in flight for id 1
    bit last;            // who won the most recent AR
  } model_t;

  model_t m = '{pend: 0, pid: 0, paddr: '0, psize: '0, cnt0: 0, cnt1: 0, last: 0};

  function automatic model_t model_next(model_t c);
    model_t n = c;
    bit ie, de, pick;
    if (!resetn) begin
      n.pend = 0; n.cnt0 = 0; n.cnt1 = 0; n.last = 0;
      return n;
    end
    if (rvalid && rid == 4'd0 && c.cnt0 > 0) n.cnt0 = n.cnt0 - 1;
    if (rvalid && rid == 4'd1 && c.cnt1 > 0) n.cnt1 = n.cnt1 - 1;
    if (c.pend) begin
      if (arready) begin
        if (c.pid) n.cnt1 = n.cnt1 + 1; else n.cnt0 = n.cnt0 + 1;
        n.last = c.pid;
        n.pend = 0;
      end
    end else begin
      ie = inst_req && c.cnt0 < FULL;
      de = data_req && !wr_related && c.cnt1 < FULL;
`ifdef RD_ARB_RR_EN
      pick = de && (!ie || c.last == 1'b0);
`else
      pick = de;
`endif
      if (ie || de) begin
        n.pend = 1;
        n.pid = pick;
        n.paddr = pick ? data_addr : inst_addr;
        n.psize = pick ? data_size : 3'd2;
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m);

  // per-cycle compare process
  always @(negedge clk) begin
    bit rv, eido, edo;
    if (started) begin
      rv = resetn;
      chk("arvalid", arvalid, rv && m.pend);
      chk("inst_addr_ok", inst_addr_ok, rv && m.pend && arready && !m.pid);
      chk("data_addr_ok", data_addr_ok, rv && m.pend && arready && m.pid);
      if (rv && m.pend) begin
        chk("arid", arid, {3'b0, m.pid});
        chk("araddr", araddr, m.paddr);
        chk("arsize", arsize, m.psize);
      end
      eido = rv && rvalid && rid == 4'd0 && m.cnt0 > 0;
      edo  = rv && rvalid && rid == 4'd1 && m.cnt1 > 0;
      chk("inst_data_ok", inst_data_ok, eido);
      chk("data_data_ok", data_data_ok, edo);
      if (eido) chk("inst_rdata", inst_rdata, rdata);
      if (edo) chk("data_rdata", data_rdata, rdata);
      chk("rready", rready, 1);
      chk("check_addr", check_addr, data_addr);
      if (rv) chk("dbg_state", dbg_state, m.pend);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 0; data_req = 0; wr_related = 0; arready = 0; rvalid = 0; rid = '0;
  endtask

  task automatic do_reset();
    step();
    clear_inputs();
    resetn = 0;
    step();
    step();
    resetn = 1;
  endtask

  task automatic wait_ok(input int which, input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if ((which == 0 && inst_addr_ok) || (which == 1 && data_addr_ok)) seen = 1;
      else step();
    end
  endtask

  initial begin
    bit seen;
    int n;
    bit got_q[$];
    bit exp_seq[4];

    // reset state
    do_reset();
    @(negedge clk);
    chk("reset_arvalid", arvalid, 0);
    chk("reset_inst_addr_ok", inst_addr_ok, 0);
    chk("reset_araddr", araddr, 0);

    // single inst fetch and its response
    step();
    inst_req = 1; inst_addr = 32'h1C00_0000; arready = 1;
    step();
    inst_req = 0;
    @(negedge clk);
    chk("fetch_arvalid_cycle2", arvalid, 1);
    chk("fetch_arid", arid, 0);
    chk("fetch_arsize", arsize, 2);
    chk("fetch_araddr", araddr, 32'h1C00_0000);
    chk("fetch_addr_ok", inst_addr_ok, 1);
    step();
    rvalid = 1; rid = 4'd0; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("fetch_data_ok", inst_data_ok, 1);
    chk("fetch_rdata", inst_rdata, 32'hDEAD_BEEF);
    step();
    rvalid = 0;

    // both requesters held: grant order
    do_reset();
    inst_req = 1; inst_addr = 32'h100; data_req = 1; data_addr = 32'h200;
    data_size = 3'b001; arready = 1;
    for (int i = 0; i < 20 && got_q.size() < 4; i++) begin
      @(negedge clk);
      if (inst_addr_ok) got_q.push_back(1'b0);
      if (data_addr_ok) got_q.push_back(1'b1);
      step();
    end
`ifdef RD_ARB_RR_EN
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    chk("grant_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("grant_order", got_q[i], exp_seq[i]);

    // inst outstanding limit
    do_reset();
    inst_req = 1; inst_addr = 32'h300; arready = 1;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (inst_addr_ok) n++;
      step();
    end
    chk("limit_four_ars", n, 4);
    rvalid = 1; rid = 4'd0; rdata = 32'h1234_5678;
    @(negedge clk);
    chk("limit_resp_ok", inst_data_ok, 1);
    step();
    rvalid = 0;
    wait_ok(0, 6, seen);
    chk("limit_fifth_ar", seen, 1);
    step();
    inst_req = 0;

    // write hazard blocks data reads while IDLE
    do_reset();
    data_req = 1; data_addr = 32'h400; data_size = 3'b010; wr_related = 1; arready = 1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (arvalid || data_addr_ok) n++;
      step();
    end
    chk("hazard_no_ar", n, 0);
    wr_related = 0;
    wait_ok(1, 5, seen);
    chk("hazard_ar_follows", seen, 1);
    step();
    data_req = 0;

    // reset while an AR is pending
    do_reset();
    arready = 0; inst_req = 1; inst_addr = 32'h500;
    step();
    inst_req = 0;
    @(negedge clk);
    chk("pend_arvalid", arvalid, 1);
    step();
    resetn = 0; arready = 1;
    @(negedge clk);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_addr_ok", inst_addr_ok, 0);
    step();
    resetn = 1;
    @(negedge clk);
    chk("post_rst_arvalid", arvalid, 0);
    chk("post_rst_addr_ok", inst_addr_ok, 0);
    step();
    rvalid = 1; rid = 4'd0;
    @(negedge clk);
    chk("post_rst_cnt_zero", inst_data_ok, 0);
    step();
    rvalid = 0;

    // stray data response with nothing outstanding
    rvalid = 1; rid = 4'd1; rdata = 32'hCAFE_0001;
    @(negedge clk);
    chk("stray_data_ok", data_data_ok, 0);
    step();
    rvalid = 0; data_req = 1; data_addr = 32'h600; arready = 1;
    wait_ok(1, 5, seen);
    chk("one_data_ar", seen, 1);
    step();
    data_req = 0; rvalid = 1; rid = 4'd1; rdata = 32'hCAFE_0002;
    @(negedge clk);
    chk("one_data_ok", data_data_ok, 1);
    chk("one_data_rdata", data_rdata, 32'hCAFE_0002);
    step();
    @(negedge clk);
    chk("second_stray_ok", data_data_ok, 0);
    step();
    rvalid = 0;

    // randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 3000; i++) begin
      step();
      resetn     = ($urandom_range(0, 99) != 0);
      inst_req   = ($urandom_range(0, 9) < 6);
      data_req   = ($urandom_range(0, 9) < 6);
      wr_related = ($urandom_range(0, 9) < 3);
      arready    = ($urandom_range(0, 9) < 6);
      rvalid     = ($urandom_range(0, 9) < 4);
      rid        = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(2, 15));
      rdata      = $urandom;
      inst_addr  = $urandom;
      data_addr  = $urandom;
      data_size  = 3'($urandom_range(0, 7));
    end
    step();
    clear_inputs();
    resetn = 1;
    step();
    step();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // time limit
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
